// File: rtl/cla_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_seq_adder
//
// Multi-cycle WIDTH-bit adder that time-shares one external 4-bit carry
// lookahead slice. The operands are latched on an accepted start. Each RUN
// cycle handles one 4-bit slice, least significant first:
//   - it drives that slice's generate/propagate terms and the running carry
//     into the CLA;
//   - it reads the CLA's carries back in the same cycle;
//   - it writes that slice's sum bits and carries C4 into the next slice.
//
// Optional feature: define CLA_SUB_EN to add the 'sub' input. With sub=1 the
// block computes a - b: B is latched inverted and the initial carry is
// forced to 1.
//
// Parameters
//   WIDTH    operand width, must be a multiple of 4 (NSLICE = WIDTH/4)
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        request, sampled only in IDLE
//   a, b, cin    operands and carry-in, latched on accepted start
//   sub          (CLA_SUB_EN only) subtract select, latched on accepted start
//   busy         high in RUN and DONE
//   done         one-cycle pulse. Results are valid from this cycle on.
//   sum          result. It is held until each slice is rewritten by the
//                next operation.
//   cout, ovf    carry out of the MSB, signed overflow
//   cla_g/p/cin  to the shared CLA slice, zero outside RUN
//   cla_c        from the CLA, {C4,C3,C2,C1}, combinational return
//
// Handshake: start is a request with no ready. It is accepted when start=1 at
// a rising edge while idle (busy=0). Requests while busy are dropped, not
// queued.
// -----------------------------------------------------------------------------
module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       cla_g,
    output logic [3:0]       cla_p,
    output logic             cla_cin,
    input  logic [3:0]       cla_c
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [3:0]       a_s;
    logic [3:0]       b_s;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             accept;
    logic             last;

    // Operand conditioning at capture time. Subtraction is a + ~b + 1.
`ifdef CLA_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign accept = (state == S_IDLE) && start;
    assign last   = (idx == IDXW'(NSLICE - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Select the current 4-bit slice from the latched operands.
    always_comb begin
        a_s = 4'd0;
        b_s = 4'd0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDXW'(i)) begin
                a_s = a_q[i*4 +: 4];
                b_s = b_q[i*4 +: 4];
            end
        end
    end

    // CLA drive is gated so the shared slice sees zeros when we are not using it.
    always_comb begin
        cla_g   = 4'd0;
        cla_p   = 4'd0;
        cla_cin = 1'b0;
        if (state == S_RUN) begin
            cla_g   = a_s & b_s;
            cla_p   = a_s ^ b_s;
            cla_cin = carry;
        end
    end

    // Datapath: operand capture and slice-by-slice result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b_in;
            carry <= c_in;
            idx   <= '0;
        end else if (state == S_RUN) begin
            // Carry into bit k of the slice is C_k, with C0 = running carry.
            for (int i = 0; i < NSLICE; i++) begin
                if (idx == IDXW'(i)) begin
                    sum[i*4 +: 4] <= cla_p ^ {cla_c[2:0], carry};
                end
            end
            carry <= cla_c[3];
            idx   <= idx + IDXW'(1);
            if (last) begin
                cout <= cla_c[3];
                // C3 of the top slice is the carry into the MSB.
                ovf  <= cla_c[2] ^ cla_c[3];
            end
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_seq_adder
//
// Bench for cla_seq_adder at WIDTH=16, with a behavioural 4-bit CLA slice
// standing in for the shared external instance. Results are predicted from
// whole-word arithmetic on the operands. Define CLA_SUB_EN to include the
// subtract case.
// -----------------------------------------------------------------------------
module tb_cla_seq_adder;

    localparam int W      = 16;
    localparam int NSLICE = W / 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [3:0]   cla_g;
    logic [3:0]   cla_p;
    logic         cla_cin;
    logic [3:0]   cla_c;

    int passed;
    int total;
    logic [W-1:0] last_sum;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
`ifdef CLA_SUB_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .ovf     (ovf),
        .cla_g   (cla_g),
        .cla_p   (cla_p),
        .cla_cin (cla_cin),
        .cla_c   (cla_c)
    );

    // External CLA slice (environment, not the reference model).
    always_comb begin
        logic c;
        cla_c = 4'd0;
        c     = cla_cin;
        for (int i = 0; i < 4; i++) begin
            c        = cla_g[i] | (cla_p[i] & c);
            cla_c[i] = c;
        end
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W:0]   full;
        logic [W-1:0] beff;
        logic         c0;
        logic         v;
        logic         s;
        s    = 1'b0;
`ifdef CLA_SUB_EN
        s    = msub;
`endif
        beff = s ? ~mb : mb;
        c0   = s ? 1'b1 : mcin;
        full = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, c0};
        v    = (ma[W-1] == beff[W-1]) && (full[W-1] != ma[W-1]);
        return {v, full};   // {ovf, cout, sum}
    endfunction

    // ---------------- driver ----------------
    // Issues one operation from a negedge. Returns the latency in cycles from
    // the accept edge to done, the results and a snapshot taken in the first
    // RUN cycle.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                          input logic isub,
                          output int lat, output logic [W-1:0] osum, output logic ocout,
                          output logic oovf, output logic [W-1:0] sum_run0,
                          output logic [3:0] g_run0, output logic cin_run0,
                          output logic busy_run0, output logic busy_after);
        a     = ia;
        b     = ib;
        cin   = icin;
        sub   = isub;
        start = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start     = 1'b0;
                sum_run0  = sum;
                g_run0    = cla_g;
                cin_run0  = cla_cin;
                busy_run0 = busy;
                // Operands changing after the accept must have no effect.
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
            end
            if (done) begin
                lat = k - 1;
                break;
            end
        end
        osum  = sum;
        ocout = cout;
        oovf  = ovf;
        @(negedge clk);
        busy_after = busy | done;
    endtask

    // Full check of one operation against the model.
    task automatic test_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic icin, input logic isub);
        int           lat;
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic [W-1:0] s0;
        logic [3:0]   g0;
        logic         ci0;
        logic         bz0;
        logic         bza;
        logic [W+1:0] exp_v;
        logic [W-1:0] exp_b;
        logic         exp_c0;
        logic [W-1:0] prev;
        prev   = last_sum;
        exp_v  = model(ia, ib, icin, isub);
        exp_b  = ib;
        exp_c0 = icin;
`ifdef CLA_SUB_EN
        if (isub) begin
            exp_b  = ~ib;
            exp_c0 = 1'b1;
        end
`endif
        run_op(ia, ib, icin, isub, lat, s, c, o, s0, g0, ci0, bz0, bza);
        total++;
        if (lat !== NSLICE) $display("FAIL %s latency got=%0d exp=%0d", name, lat, NSLICE);
        else passed++;
        total++;
        if (s !== exp_v[W-1:0]) $display("FAIL %s sum got=%h exp=%h", name, s, exp_v[W-1:0]);
        else passed++;
        total++;
        if (c !== exp_v[W]) $display("FAIL %s cout got=%b exp=%b", name, c, exp_v[W]);
        else passed++;
        total++;
        if (o !== exp_v[W+1]) $display("FAIL %s ovf got=%b exp=%b", name, o, exp_v[W+1]);
        else passed++;
        total++;
        if (s0 !== prev) $display("FAIL %s sum_kept_at_start got=%h exp=%h", name, s0, prev);
        else passed++;
        total++;
        if ({bz0, ci0, g0} !== {1'b1, exp_c0, ia[3:0] & exp_b[3:0]})
            $display("FAIL %s first_slice busy/cin/g got=%b%b%h exp=1%b%h", name, bz0, ci0, g0,
                     exp_c0, ia[3:0] & exp_b[3:0]);
        else passed++;
        total++;
        if (bza !== 1'b0) $display("FAIL %s idle_after_done got=%b exp=0", name, bza);
        else passed++;
        total++;
        if ({cla_g, cla_p, cla_cin} !== 9'd0)
            $display("FAIL %s cla_idle got=%h exp=0", name, {cla_g, cla_p, cla_cin});
        else passed++;
        last_sum = exp_v[W-1:0];
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, sum, cout, ovf} !== '0)
            $display("FAIL reset_outputs got=%h exp=0", {busy, done, sum, cout, ovf});
        else passed++;
        total++;
        if ({cla_g, cla_p, cla_cin} !== 9'd0)
            $display("FAIL reset_cla got=%h exp=0", {cla_g, cla_p, cla_cin});
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        last_sum = '0;
    endtask

    task automatic test_idle_no_start();
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) $display("FAIL idle_no_start got=%b exp=00", {busy, done});
        else passed++;
    endtask

    task automatic test_directed();
        test_op("zero", 16'h0000, 16'h0000, 1'b0, 1'b0);
        test_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        test_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        test_op("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0);
        test_op("cin_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_start_held();
        int           dones;
        logic         busy_end;
        logic [W-1:0] s;
        a     = 16'h1234;
        b     = 16'h4321;
        cin   = 1'b1;
        sub   = 1'b0;
        start = 1'b1;
        dones = 0;
        s     = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                a = 16'hAAAA;
                b = 16'h5555;
            end
            if (done) begin
                dones++;
                s = sum;
            end
        end
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        busy_end = busy;
        total++;
        if (dones !== 1) $display("FAIL start_held done_count got=%0d exp=1", dones);
        else passed++;
        total++;
        if (s !== 16'h5556) $display("FAIL start_held sum got=%h exp=5556", s);
        else passed++;
        total++;
        if (busy_end !== 1'b0) $display("FAIL start_held busy_end got=%b exp=0", busy_end);
        else passed++;
        last_sum = 16'h5556;
    endtask

    task automatic test_reset_abort();
        int dones;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b1;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, sum, cout, ovf} !== '0)
            $display("FAIL reset_abort outputs got=%h exp=0", {busy, done, sum, cout, ovf});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        total++;
        if (dones !== 0) $display("FAIL reset_abort done_count got=%0d exp=0", dones);
        else passed++;
        last_sum = '0;
        test_op("after_reset", 16'h1111, 16'h2222, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
`ifdef CLA_SUB_EN
        test_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1);
        test_op("sub_7_5", 16'h0007, 16'h0005, 1'b0, 1'b1);
        test_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_random_back_to_back();
        for (int n = 0; n < 30; n++) begin
            logic sb;
            sb = 1'b0;
`ifdef CLA_SUB_EN
            sb = 1'($urandom_range(0, 1));
`endif
            test_op("random", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), sb);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        passed   = 0;
        total    = 0;
        last_sum = '0;
        test_reset();
        test_idle_no_start();
        test_directed();
        test_start_held();
        test_reset_abort();
        test_sub();
        test_random_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
